hwpf_stride_train: RTL and testbench

- Self-training stride prefetcher, next generation of the HPDcache linear prefetcher.
- Learns a signed cacheline stride from snooped demand accesses, with no software-programmed base or stride.
- After a configurable number of confirming deltas, issues a burst of prefetch cacheline requests towards the HPDcache CMO-prefetch request adapter.
- Throttled by an in-flight limit; retrains on a stride change.

---
 rtl/hwpf_stride_train.sv | 196 +++++++++++++++++++
 tb/tb_hwpf_stride_train.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpf_stride_train.sv
// Self-training stride prefetcher: learns a signed cacheline stride from snooped demand accesses
// and issues throttled prefetch bursts. Define HWPF_STRIDE_PAGE_BOUND_EN to stop bursts at the trigger's page.
module hwpf_stride_train #(
    parameter int NLINE_WIDTH     = 26,
    parameter int STRIDE_WIDTH    = 12,
    parameter int DEPTH_WIDTH     = 4,
    parameter int CONF_WIDTH      = 3,
    parameter int INFLIGHT_WIDTH  = 4,
    parameter int PAGE_NLINE_BITS = 6
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           enable_i,
    input  logic [CONF_WIDTH-1:0]          cfg_conf_i,
    input  logic [DEPTH_WIDTH-1:0]         cfg_depth_i,
    input  logic [INFLIGHT_WIDTH-1:0]      cfg_max_inflight_i,
    input  logic                           snoop_valid_i,
    input  logic [NLINE_WIDTH-1:0]         snoop_nline_i,
    output logic                           req_valid_o,
    input  logic                           req_ready_i,
    output logic [NLINE_WIDTH-1:0]         req_nline_o,
    input  logic                           rsp_valid_i,
    output logic                           busy_o,
    output logic signed [STRIDE_WIDTH-1:0] stride_o,
    output logic [CONF_WIDTH-1:0]          conf_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] TRAIN = 2'd1;
    localparam logic [1:0] ISSUE = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    localparam int PW = NLINE_WIDTH - PAGE_NLINE_BITS;
    localparam logic [CONF_WIDTH-1:0]     CONF_MAX = '1;
    localparam logic [INFLIGHT_WIDTH-1:0] INFL_MAX = '1;

`ifdef HWPF_STRIDE_PAGE_BOUND_EN
    localparam bit PAGE_BOUND_EN = 1'b1;
`else
    localparam bit PAGE_BOUND_EN = 1'b0;
`endif

    function automatic logic [NLINE_WIDTH-1:0] sext_stride(input logic signed [STRIDE_WIDTH-1:0] s);
        return {{(NLINE_WIDTH-STRIDE_WIDTH){s[STRIDE_WIDTH-1]}}, s};
    endfunction

    // The wrapped difference fits the stride when its upper bits are a pure sign extension.
    function automatic logic fits_stride(input logic [NLINE_WIDTH-STRIDE_WIDTH:0] hi);
        return (&hi) || !(|hi);
    endfunction

    logic [1:0]                     state, state_n;
    logic                           hist_valid, hist_valid_n;
    logic [NLINE_WIDTH-1:0]         last, last_n;
    logic signed [STRIDE_WIDTH-1:0] stride, stride_n;
    logic [CONF_WIDTH-1:0]          conf, conf_n;
    logic [NLINE_WIDTH-1:0]         next_nline, next_nline_n;
    logic [DEPTH_WIDTH-1:0]         remain, remain_n;
    logic [INFLIGHT_WIDTH-1:0]      inflight, inflight_n;
    logic                           abort_pend, abort_pend_n;
    logic [PW-1:0]                  trig_page, trig_page_n;

    logic                           train_upd, delta_fits, delta_match, mismatch;
    logic [NLINE_WIDTH-1:0]         diff;
    logic signed [STRIDE_WIDTH-1:0] delta, stride_upd;
    logic [CONF_WIDTH-1:0]          conf_upd, conf_thr;
    logic                           inflight_ok, page_ok, hs, abort;

    assign train_upd   = snoop_valid_i && (state == TRAIN || state == ISSUE);
    assign diff        = snoop_nline_i - last;
    assign delta       = diff[STRIDE_WIDTH-1:0];
    assign delta_fits  = fits_stride(diff[NLINE_WIDTH-1:STRIDE_WIDTH-1]);
    assign delta_match = hist_valid && delta_fits && (delta != '0) && (delta == stride);
    assign mismatch    = train_upd && hist_valid && !delta_match;
    assign stride_upd  = delta_fits ? delta : '0;
    assign conf_upd    = !delta_match ? '0 : (conf == CONF_MAX) ? conf : conf + CONF_WIDTH'(1);
    assign conf_thr    = (cfg_conf_i == '0) ? CONF_WIDTH'(1) : cfg_conf_i;

    assign inflight_ok = (cfg_max_inflight_i == '0) || (inflight < cfg_max_inflight_i);
    assign page_ok     = !PAGE_BOUND_EN || (next_nline[NLINE_WIDTH-1:PAGE_NLINE_BITS] == trig_page);
    assign req_valid_o = (state == ISSUE) && inflight_ok && page_ok;
    assign hs          = req_valid_o && req_ready_i;
    assign abort       = abort_pend || mismatch;

    assign req_nline_o = next_nline;
    assign busy_o      = (state == ISSUE) || (state == DRAIN);
    assign stride_o    = stride;
    assign conf_o      = conf;

    always_comb begin
        inflight_n = inflight;
        if (hs && !rsp_valid_i) begin
            if (inflight != INFL_MAX) inflight_n = inflight + INFLIGHT_WIDTH'(1);
        end else if (!hs && rsp_valid_i) begin
            if (inflight != '0) inflight_n = inflight - INFLIGHT_WIDTH'(1);
        end
    end

    always_comb begin
        state_n      = state;
        hist_valid_n = hist_valid;
        last_n       = last;
        stride_n     = stride;
        conf_n       = conf;
        next_nline_n = next_nline;
        remain_n     = remain;
        abort_pend_n = abort_pend;
        trig_page_n  = trig_page;

        if (train_upd) begin
            last_n = snoop_nline_i;
            if (!hist_valid) begin
                hist_valid_n = 1'b1;
            end else begin
                stride_n = stride_upd;
                conf_n   = conf_upd;
            end
        end

        case (state)
            IDLE: begin
                if (enable_i) begin
                    state_n      = TRAIN;
                    hist_valid_n = 1'b0;
                    conf_n       = '0;
                    stride_n     = '0;
                    abort_pend_n = 1'b0;
                end
            end
            TRAIN: begin
                if (!enable_i) begin
                    state_n = DRAIN;
                end else if (train_upd && delta_match && (conf_upd >= conf_thr) && (cfg_depth_i != '0)) begin
                    state_n      = ISSUE;
                    next_nline_n = snoop_nline_i + sext_stride(stride);
                    remain_n     = cfg_depth_i;
                    abort_pend_n = 1'b0;
                    trig_page_n  = snoop_nline_i[NLINE_WIDTH-1:PAGE_NLINE_BITS];
                end
            end
            ISSUE: begin
                // A handshake always advances with the stride the burst was started with.
                if (hs) begin
                    next_nline_n = next_nline + sext_stride(stride);
                    remain_n     = remain - DEPTH_WIDTH'(1);
                end
                if (!enable_i) begin
                    if (!req_valid_o || hs) begin
                        state_n      = DRAIN;
                        abort_pend_n = 1'b0;
                    end
                end else if (abort) begin
                    if (!req_valid_o || hs) begin
                        state_n      = TRAIN;
                        abort_pend_n = 1'b0;
                    end else begin
                        abort_pend_n = 1'b1;
                    end
                end else if ((hs && remain == DEPTH_WIDTH'(1)) || !page_ok) begin
                    state_n = TRAIN;
                    conf_n  = '0;
                end
            end
            default: begin
                if (inflight_n == '0) state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            hist_valid <= 1'b0;
            last       <= '0;
            stride     <= '0;
            conf       <= '0;
            next_nline <= '0;
            remain     <= '0;
            inflight   <= '0;
            abort_pend <= 1'b0;
            trig_page  <= '0;
        end else begin
            state      <= state_n;
            hist_valid <= hist_valid_n;
            last       <= last_n;
            stride     <= stride_n;
            conf       <= conf_n;
            next_nline <= next_nline_n;
            remain     <= remain_n;
            inflight   <= inflight_n;
            abort_pend <= abort_pend_n;
            trig_page  <= trig_page_n;
        end
    end

endmodule

// File: tb/tb_hwpf_stride_train.sv
// Directed and randomized bench for hwpf_stride_train against a transaction-level stride model.
module tb_hwpf_stride_train;

    localparam int NW = 26;
    localparam int SW = 12;
    localparam int DW = 4;
    localparam int CW = 3;
    localparam int IW = 4;
    localparam int PB = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [CW-1:0] conf_cfg;
    logic [DW-1:0] depth_cfg;
    logic [IW-1:0] maxinf_cfg;
    logic          snoop_valid;
    logic [NW-1:0] snoop_nline;
    logic          req_valid;
    logic          req_ready;
    logic [NW-1:0] req_nline;
    logic          rsp_valid;
    logic          busy;
    logic [SW-1:0] stride;
    logic [CW-1:0] conf;

    always #5 clk = ~clk;

    hwpf_stride_train #(
        .NLINE_WIDTH(NW), .STRIDE_WIDTH(SW), .DEPTH_WIDTH(DW),
        .CONF_WIDTH(CW), .INFLIGHT_WIDTH(IW), .PAGE_NLINE_BITS(PB)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable),
        .cfg_conf_i(conf_cfg), .cfg_depth_i(depth_cfg), .cfg_max_inflight_i(maxinf_cfg),
        .snoop_valid_i(snoop_valid), .snoop_nline_i(snoop_nline),
        .req_valid_o(req_valid), .req_ready_i(req_ready), .req_nline_o(req_nline),
        .rsp_valid_i(rsp_valid), .busy_o(busy), .stride_o(stride), .conf_o(conf)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [NW-1:0] got_q[$];
    int            got_cyc[$];
    int            got_base = 0;
    logic [NW-1:0] exp_q[$];

    // Reference training state: last line, learned stride (plain signed int) and confidence.
    logic [NW-1:0] m_last;
    int            m_stride;
    int            m_conf;
    bit            m_hist;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && req_valid && req_ready) begin
            got_q.push_back(req_nline);
            got_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic bit m_snoop(input logic [NW-1:0] sn, input bit in_train);
        logic [NW-1:0] d;
        int sd;
        int thr;
        bit ok;
        bit trig;
        trig = 1'b0;
        if (!m_hist) begin
            m_hist = 1'b1;
        end else begin
            d  = sn - m_last;
            sd = int'(d);
            if (sd >= (1 << (NW-1))) sd = sd - (1 << NW);
            ok = (sd >= -(1 << (SW-1))) && (sd < (1 << (SW-1)));
            if (ok && sd != 0 && sd == m_stride) begin
                if (m_conf < (1 << CW) - 1) m_conf++;
                thr  = (conf_cfg == '0) ? 1 : int'(conf_cfg);
                trig = in_train && (m_conf >= thr) && (depth_cfg != '0);
            end else begin
                m_stride = ok ? sd : 0;
                m_conf   = 0;
            end
        end
        m_last = sn;
        return trig;
    endfunction

    task automatic m_burst(input logic [NW-1:0] trig);
        logic [NW-1:0] n;
        n = trig;
        for (int k = 0; k < int'(depth_cfg); k++) begin
            n = n + NW'(m_stride);
`ifdef HWPF_STRIDE_PAGE_BOUND_EN
            if ((n >> PB) != (trig >> PB)) break;
`endif
            exp_q.push_back(n);
        end
        m_conf = 0;
    endtask

    task automatic send(input logic [NW-1:0] n, input bit in_train, output bit trig);
        trig = m_snoop(n, in_train);
        if (trig) m_burst(n);
        snoop_nline = n;
        snoop_valid = 1'b1;
        tick(1);
        snoop_valid = 1'b0;
    endtask

    task automatic cmp_bursts(input string tag);
        int n_got;
        n_got = got_q.size() - got_base;
        chk({tag, "_count"}, 64'(n_got), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < n_got; i++)
            chk({tag, "_nline"}, 64'(got_q[got_base + i]), 64'(exp_q[i]));
        got_base = got_q.size();
        exp_q.delete();
    endtask

    task automatic chk_train(input string tag);
        logic [SW-1:0] ms;
        ms = m_stride[SW-1:0];
        chk({tag, "_stride"}, 64'(stride), 64'(ms));
        chk({tag, "_conf"}, 64'(conf), 64'(m_conf));
    endtask

    task automatic clear_inflight();
        rsp_valid = 1'b1;
        tick(16);
        rsp_valid = 1'b0;
    endtask

    initial begin
        bit t;
        logic [NW-1:0] e0;
        logic [NW-1:0] base;
        int s;

        rst_n = 1'b0; enable = 1'b0; conf_cfg = '0; depth_cfg = '0; maxinf_cfg = '0;
        snoop_valid = 1'b0; snoop_nline = '0; req_ready = 1'b0; rsp_valid = 1'b0;
        m_last = '0; m_stride = 0; m_conf = 0; m_hist = 1'b0;
        tick(3);
        chk("rst_req_valid", 64'(req_valid), 64'(0));
        chk("rst_req_nline", 64'(req_nline), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_stride", 64'(stride), 64'(0));
        chk("rst_conf", 64'(conf), 64'(0));
        rst_n = 1'b1;
        tick(1);

        // Stride +2, threshold 2, burst of 3 on consecutive cycles
        enable = 1'b1; conf_cfg = 3'd2; depth_cfg = 4'd3; req_ready = 1'b1;
        tick(1);
        send(26'h100, 1'b1, t); send(26'h102, 1'b1, t); send(26'h104, 1'b1, t); send(26'h106, 1'b1, t);
        chk("t1_trigger", 64'(t), 64'(1));
        tick(6);
        for (int i = got_base + 1; i < got_cyc.size(); i++)
            chk("t1_consecutive", 64'(got_cyc[i] - got_cyc[i-1]), 64'(1));
        cmp_bursts("t1");
        chk_train("t1");
        chk("t1_busy", 64'(busy), 64'(0));

        // Negative stride -1, threshold 1, depth 2
        conf_cfg = 3'd1; depth_cfg = 4'd2;
        send(26'h050, 1'b1, t); send(26'h04F, 1'b1, t); send(26'h04E, 1'b1, t);
        tick(5);
        cmp_bursts("t2");
        chk("t2_stride_ones", 64'(stride), 64'(12'hFFF));

        // In-flight limit of 2 with depth 4
        clear_inflight();
        maxinf_cfg = 4'd2; depth_cfg = 4'd4;
        send(26'h200, 1'b1, t); send(26'h201, 1'b1, t); send(26'h202, 1'b1, t);
        tick(5);
        chk("t3_limit_count", 64'(got_q.size() - got_base), 64'(2));
        chk("t3_limit_valid", 64'(req_valid), 64'(0));
        chk("t3_limit_busy", 64'(busy), 64'(1));
        rsp_valid = 1'b1; tick(1); rsp_valid = 1'b0;
        chk("t3_resume_valid", 64'(req_valid), 64'(1));
        chk("t3_resume_nline", 64'(req_nline), 64'(exp_q[2]));
        tick(3);
        rsp_valid = 1'b1; tick(1); rsp_valid = 1'b0;
        tick(3);
        cmp_bursts("t3");
        chk("t3_done_busy", 64'(busy), 64'(0));

        // Mismatching snoop while the head request is stalled
        maxinf_cfg = '0; req_ready = 1'b0; conf_cfg = 3'd1; depth_cfg = 4'd4;
        send(26'h300, 1'b1, t); send(26'h303, 1'b1, t); send(26'h306, 1'b1, t);
        e0 = exp_q[0];
        exp_q.delete();
        exp_q.push_back(e0);
        chk("t4_valid", 64'(req_valid), 64'(1));
        chk("t4_nline", 64'(req_nline), 64'(e0));
        send(26'h400, 1'b0, t);
        for (int i = 0; i < 3; i++) begin
            chk("t4_hold_valid", 64'(req_valid), 64'(1));
            chk("t4_hold_nline", 64'(req_nline), 64'(e0));
            tick(1);
        end
        req_ready = 1'b1;
        tick(1);
        chk("t4_abort_busy", 64'(busy), 64'(0));
        chk("t4_abort_valid", 64'(req_valid), 64'(0));
        tick(4);
        cmp_bursts("t4");
        chk_train("t4");

        // Disable with three requests outstanding
        clear_inflight();
        conf_cfg = 3'd1; depth_cfg = 4'd3;
        send(26'h500, 1'b1, t); send(26'h501, 1'b1, t); send(26'h502, 1'b1, t);
        tick(6);
        cmp_bursts("t5");
        enable = 1'b0;
        tick(1);
        chk("t5_drain_busy", 64'(busy), 64'(1));
        enable = 1'b1;
        tick(2);
        chk("t5_reenable_ignored", 64'(busy), 64'(1));
        for (int i = 0; i < 3; i++) begin
            rsp_valid = 1'b1; tick(1); rsp_valid = 1'b0;
            chk("t5_rsp_busy", 64'(busy), 64'((i < 2) ? 1 : 0));
        end
        tick(1);
        m_hist = 1'b0; m_conf = 0; m_stride = 0;
        chk_train("t5_retrain");
        chk("t5_retrain_busy", 64'(busy), 64'(0));

`ifdef HWPF_STRIDE_PAGE_BOUND_EN
        conf_cfg = 3'd1; depth_cfg = 4'd4;
        send(26'h13C, 1'b1, t); send(26'h13D, 1'b1, t); send(26'h13E, 1'b1, t);
        tick(6);
        if (got_q.size() > got_base) chk("pg_first", 64'(got_q[got_base]), 64'(26'h13F));
        cmp_bursts("pg");
        chk("pg_busy", 64'(busy), 64'(0));
`endif

        // Depth 0 trains only; confidence saturates
        conf_cfg = 3'd3; depth_cfg = '0;
        for (int k = 0; k < 11; k++) send(26'h700 + NW'(4 * k), 1'b1, t);
        tick(3);
        chk("d0_conf_sat", 64'(conf), 64'(7));
        cmp_bursts("d0");
        depth_cfg = 4'd2;
        send(26'h700 + NW'(44), 1'b1, t);
        chk("d0_trigger", 64'(t), 64'(1));
        tick(5);
        cmp_bursts("d0_go");

        // Random bases (including wrap), strides and configurations
        for (int it = 0; it < 8; it++) begin
            conf_cfg  = CW'($urandom_range(0, 3));
            depth_cfg = DW'($urandom_range(1, 5));
            base      = NW'($urandom);
            s         = int'($urandom_range(1, 40));
            if ($urandom_range(0, 1) == 1) s = -s;
            t = 1'b0;
            for (int k = 0; k < 12 && !t; k++) send(base + NW'(k * s), 1'b1, t);
            chk("rnd_trigger", 64'(t), 64'(1));
            tick(8);
            cmp_bursts("rnd");
            chk_train("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
